branch_resolve_unit: RTL and testbench

- Resolution end of the local-history branch predictor loop.
- Buffers in-flight predictions (PC, predicted direction) in program order as fetch issues them.
- Retires each entry against its actual outcome from execute, then emits the predictor training update (PC, taken) and a registered mispredict/flush signal.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 tb/tb_branch_resolve_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/training/statistics signal bundle of the branch resolve unit.
// The slave modport is the resolve unit itself; the master modport is its environment.
interface branch_resolve_unit_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken;
    logic             pred_ready;

    logic             res_valid;
    logic             res_taken;
    logic             res_ready;

    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             mispredict;

    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;
    logic             protocol_err;

    modport master (
        output pred_valid, pred_pc, pred_taken, res_valid, res_taken,
        input  pred_ready, res_ready, upd_valid, upd_pc, upd_taken, mispredict,
        input  occupancy, branch_count, mispredict_count, protocol_err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, res_valid, res_taken,
        output pred_ready, res_ready, upd_valid, upd_pc, upd_taken, mispredict,
        output occupancy, branch_count, mispredict_count, protocol_err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolution end of the local-history predictor: an in-order queue of in-flight
// predictions, retired against execute outcomes into training updates and flushes.
module branch_resolve_unit #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic clock,
    input  logic reset,
    branch_resolve_unit_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    entry_t           mem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic             updValid_q, updValid_d;
    logic [PC_W-1:0]  updPc_q, updPc_d;
    logic             updTaken_q, updTaken_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_W-1:0] misCnt_q, misCnt_d;
    logic             protoErr_q, protoErr_d;

    logic             full;
    logic             empty;
    logic             deqFire;
    logic             flush;
    logic             enqFire;
    entry_t           head;

    always_comb begin
        full    = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
        empty   = (wrPtr_q == rdPtr_q);
        head    = mem_q[rdPtr_q[AW-1:0]];
        deqFire = bus.res_valid && !empty;
        flush   = deqFire && (head.pred != bus.res_taken);
        // A mispredicting resolve kills the same-cycle enqueue: it is wrong-path.
        enqFire = bus.pred_valid && !full && !flush;
    end

    always_comb begin
        wrPtr_d      = wrPtr_q + PTR_W'(enqFire);
        rdPtr_d      = flush ? wrPtr_q : (rdPtr_q + PTR_W'(deqFire));
        updValid_d   = deqFire;
        updPc_d      = deqFire ? head.pc : updPc_q;
        updTaken_d   = deqFire ? bus.res_taken : updTaken_q;
        mispredict_d = flush;
        branchCnt_d  = branchCnt_q;
        misCnt_d     = misCnt_q;
        protoErr_d   = protoErr_q || (bus.res_valid && empty);
        if (deqFire && (branchCnt_q != '1)) begin
            branchCnt_d = branchCnt_q + CNT_W'(1);
        end
        if (flush && (misCnt_q != '1)) begin
            misCnt_d = misCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            updValid_q   <= 1'b0;
            updPc_q      <= '0;
            updTaken_q   <= 1'b0;
            mispredict_q <= 1'b0;
            branchCnt_q  <= '0;
            misCnt_q     <= '0;
            protoErr_q   <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            updValid_q   <= updValid_d;
            updPc_q      <= updPc_d;
            updTaken_q   <= updTaken_d;
            mispredict_q <= mispredict_d;
            branchCnt_q  <= branchCnt_d;
            misCnt_q     <= misCnt_d;
            protoErr_q   <= protoErr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (enqFire) begin
            mem_q[wrPtr_q[AW-1:0]] <= '{pc: bus.pred_pc, pred: bus.pred_taken};
        end
    end

    assign bus.pred_ready       = !full;
    assign bus.res_ready        = !empty;
    assign bus.upd_valid        = updValid_q;
    assign bus.upd_pc           = updPc_q;
    assign bus.upd_taken        = updTaken_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.occupancy        = wrPtr_q - rdPtr_q;
    assign bus.branch_count     = branchCnt_q;
    assign bus.mispredict_count = misCnt_q;
    assign bus.protocol_err     = protoErr_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int PC_W  = 10;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    branch_resolve_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int errorCount = 0;
    int checkCount = 0;

    entry_t          mdlQ[$];
    logic            expUpdValid;
    logic [PC_W-1:0] expUpdPc;
    logic            expUpdTaken;
    logic            expMis;
    int              mdlBranch;
    int              mdlMis;
    logic            mdlErr;
    logic            seenPc1ff;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int satInc(input int v);
        return (v == (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    task automatic modelReset();
        mdlQ.delete();
        expUpdValid = 1'b0;
        expUpdPc    = '0;
        expUpdTaken = 1'b0;
        expMis      = 1'b0;
        mdlBranch   = 0;
        mdlMis      = 0;
        mdlErr      = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".upd_valid"}, 32'(bus.upd_valid), 32'(expUpdValid));
        checkOutput({tag, ".mispredict"}, 32'(bus.mispredict), 32'(expMis));
        if (expUpdValid) begin
            checkOutput({tag, ".upd_pc"}, 32'(bus.upd_pc), 32'(expUpdPc));
            checkOutput({tag, ".upd_taken"}, 32'(bus.upd_taken), 32'(expUpdTaken));
        end
        checkOutput({tag, ".occupancy"}, 32'(bus.occupancy), 32'(mdlQ.size()));
        checkOutput({tag, ".branch_count"}, 32'(bus.branch_count), 32'(mdlBranch));
        checkOutput({tag, ".mispredict_count"}, 32'(bus.mispredict_count), 32'(mdlMis));
        checkOutput({tag, ".protocol_err"}, 32'(bus.protocol_err), 32'(mdlErr));
    endtask

    // One clock of traffic: called just after a rising edge, returns just after the next one.
    task automatic applyStimulus(input string tag, input logic pv, input logic [PC_W-1:0] pc,
                                 input logic pt, input logic rv, input logic rt);
        bit     full;
        bit     empty;
        bit     deq;
        bit     enq;
        entry_t head;
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        full  = (mdlQ.size() == DEPTH);
        empty = (mdlQ.size() == 0);
        #2;
        checkOutput({tag, ".pred_ready"}, 32'(bus.pred_ready), 32'(!full));
        checkOutput({tag, ".res_ready"}, 32'(bus.res_ready), 32'(!empty));
        deq = rv && !empty;
        enq = pv && !full;
        expUpdValid = deq;
        expMis      = 1'b0;
        if (rv && empty) mdlErr = 1'b1;
        if (deq) begin
            head        = mdlQ.pop_front();
            expUpdPc    = head.pc;
            expUpdTaken = rt;
            expMis      = (head.pred != rt);
            mdlBranch   = satInc(mdlBranch);
            if (expMis) begin
                mdlMis = satInc(mdlMis);
                mdlQ.delete();
                enq = 1'b0;
            end
        end
        if (enq) mdlQ.push_back('{pc: pc, pred: pt});
        @(posedge clock);
        #1;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        if (bus.upd_valid === 1'b1 && bus.upd_pc === 10'h1FF) seenPc1ff = 1'b1;
        checkState(tag);
    endtask

    task automatic enqueue(input string tag, input logic [PC_W-1:0] pc, input logic pt);
        applyStimulus(tag, 1'b1, pc, pt, 1'b0, 1'b0);
    endtask

    task automatic resolve(input string tag, input logic rt);
        applyStimulus(tag, 1'b0, '0, 1'b0, 1'b1, rt);
    endtask

    // Resolves the model's head with its own prediction, so it never flushes.
    task automatic resolveCorrect(input string tag);
        logic rt;
        rt = (mdlQ.size() != 0) ? mdlQ[0].pred : 1'b0;
        resolve(tag, rt);
    endtask

    initial begin
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        seenPc1ff      = 1'b0;
        modelReset();

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst.in.pred_ready", 32'(bus.pred_ready), 32'd1);
        checkOutput("rst.in.res_ready", 32'(bus.res_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst.pred_ready", 32'(bus.pred_ready), 32'd1);
        checkOutput("rst.res_ready", 32'(bus.res_ready), 32'd0);
        checkState("rst");

        enqueue("inord.e0", 10'h010, 1'b1);
        enqueue("inord.e1", 10'h020, 1'b0);
        enqueue("inord.e2", 10'h030, 1'b1);
        resolve("inord.r0", 1'b1);
        checkOutput("inord.pc0", 32'(bus.upd_pc), 32'h010);
        resolve("inord.r1", 1'b0);
        checkOutput("inord.pc1", 32'(bus.upd_pc), 32'h020);
        checkOutput("inord.tk1", 32'(bus.upd_taken), 32'd0);
        resolve("inord.r2", 1'b1);
        checkOutput("inord.pc2", 32'(bus.upd_pc), 32'h030);
        checkOutput("inord.bcnt", 32'(bus.branch_count), 32'd3);
        checkOutput("inord.mcnt", 32'(bus.mispredict_count), 32'd0);
        applyStimulus("inord.idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) enqueue("full.enq", PC_W'(10'h100 + i), 1'(i % 2));
        checkOutput("full.pred_ready", 32'(bus.pred_ready), 32'd0);
        checkOutput("full.occ", 32'(bus.occupancy), 32'(DEPTH));
        enqueue("full.drop", 10'h1FF, 1'b1);
        resolveCorrect("full.r0");
        checkOutput("full.ready_again", 32'(bus.pred_ready), 32'd1);
        enqueue("full.wrap", 10'h108, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            resolveCorrect("full.drain");
            checkOutput("full.drain.pc", 32'(bus.upd_pc), 32'(10'h101 + i));
        end
        checkOutput("full.no1ff", 32'(seenPc1ff), 32'd0);

        enqueue("flush.e0", 10'h200, 1'b1);
        enqueue("flush.e1", 10'h204, 1'b1);
        enqueue("flush.e2", 10'h208, 1'b0);
        applyStimulus("flush.r", 1'b1, 10'h20C, 1'b1, 1'b1, 1'b0);
        checkOutput("flush.mis", 32'(bus.mispredict), 32'd1);
        checkOutput("flush.pc", 32'(bus.upd_pc), 32'h200);
        checkOutput("flush.occ", 32'(bus.occupancy), 32'd0);
        checkOutput("flush.res_ready", 32'(bus.res_ready), 32'd0);
        checkOutput("flush.mcnt", 32'(bus.mispredict_count), 32'd1);
        enqueue("flush.after", 10'h210, 1'b1);
        resolve("flush.after.r", 1'b1);
        checkOutput("flush.after.pc", 32'(bus.upd_pc), 32'h210);

        resolve("perr.r", 1'b1);
        checkOutput("perr.flag", 32'(bus.protocol_err), 32'd1);
        enqueue("perr.e", 10'h300, 1'b0);
        resolve("perr.r2", 1'b0);
        checkOutput("perr.sticky", 32'(bus.protocol_err), 32'd1);

        for (int i = 0; i < 5; i++) enqueue("mrst.enq", PC_W'(10'h040 + i), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("mrst.occ", 32'(bus.occupancy), 32'd0);
        checkOutput("mrst.res_ready", 32'(bus.res_ready), 32'd0);
        checkOutput("mrst.bcnt", 32'(bus.branch_count), 32'd0);
        checkOutput("mrst.mcnt", 32'(bus.mispredict_count), 32'd0);
        checkOutput("mrst.perr", 32'(bus.protocol_err), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        resolve("mrst.r", 1'b1);
        checkOutput("mrst.perr_set", 32'(bus.protocol_err), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic pv;
            logic rv;
            logic rt;
            pv = ($urandom_range(99) < 60);
            rv = ($urandom_range(99) < 45) && (mdlQ.size() != 0);
            rt = (mdlQ.size() != 0) ? mdlQ[0].pred : 1'b0;
            if ($urandom_range(99) < 12) rt = ~rt;
            applyStimulus("rand", pv, PC_W'($urandom), 1'($urandom), rv, rt);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
